sm_reg_scanner: RTL
===================

Name: sm_reg_scanner

Overview:
Parametrised register-watch sequencer that replaces the single hard-wired debug register address on the core's regAddr/regData port. It steps through NUM_CH consecutive register-file indices starting at a runtime base address and waits the configured read latency. It captures regData and presents each snapshot on a valid/ready stream for display or UART back-ends. It runs free with a programmable dwell, or one channel per step pulse.

Parameters:
ADDR_W, 5, width of regAddr (register-file index)
DATA_W, 32, width of regData and snapshot
NUM_CH, 4, number of consecutive registers scanned (1..2^ADDR_W)
DWELL_W, 16, width of dwell counter
READ_LAT, 1, cycles from regAddr change to valid regData (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  scanner run enable
mode  in  1  0 = auto scan, 1 = manual step
step  in  1  single-cycle advance pulse (manual mode only)
base_addr  in  ADDR_W  first register index; sampled at scan start of each channel
dwell  in  DWELL_W  idle cycles between channels in auto mode
regAddr  out  ADDR_W  register index to core debug port
regData  in  DATA_W  register value from core debug port
snap_valid  out  1  snapshot available
snap_ready  in  1  consumer accepts snapshot
snap_ch  out  clog2(NUM_CH) (min 1)  channel index of snapshot
snap_data  out  DATA_W  captured register value
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, ch=0, regAddr=0, snap_valid=0, snap_ch=0, snap_data=0, latency and dwell counters 0, busy=0.
- States: IDLE, WAIT, PRESENT, DWELL.
- IDLE: start when enable && (mode==0 || step). On start edge: regAddr <= (base_addr + ch) mod 2^ADDR_W, lat_cnt <= READ_LAT, go WAIT. step while not in IDLE is ignored, not queued. step in auto mode is ignored.
- WAIT: lat_cnt decrements each cycle. On the edge where lat_cnt==1: snap_data <= regData, snap_ch <= ch, snap_valid <= 1, go PRESENT. regData is sampled exactly READ_LAT edges after regAddr updates.
- PRESENT: snap_valid, snap_ch and snap_data are held stable until snap_valid && snap_ready. On handshake: snap_valid <= 0, ch <= (ch==NUM_CH-1) ? 0 : ch+1. Auto: dwell==0 → IDLE, else dwell_cnt <= dwell, go DWELL. Manual → IDLE.
- DWELL: dwell_cnt decrements. When it reaches 0 → IDLE. enable=0 or mode=1 → IDLE next edge.
- enable deassert in WAIT/PRESENT: the current snapshot completes (valid is never withdrawn). The FSM then returns to IDLE and does not restart.
- regAddr holds its last value outside WAIT.
- Auto throughput with snap_ready=1: one snapshot every 2+READ_LAT+dwell cycles (READ_LAT=1, dwell=0 → 3 cycles).
- Address wrap: base_addr + ch overflowing 2^ADDR_W wraps (base 30, ch 3, ADDR_W 5 → regAddr 1).
- ch is not reset by base_addr change. Only rst clears ch.

Optional Feature:
SM_SCAN_CHANGE_ONLY_EN
- Defined: per-channel shadow register and seen flag, all cleared by rst. At capture, if seen[ch] && regData==shadow[ch], no snapshot is presented. snap_valid stays 0, ch advances and the FSM proceeds as after a handshake (DWELL or IDLE). Otherwise present normally. shadow[ch] <= regData and seen[ch] <= 1 on every capture.
- Undefined: every capture is presented; no shadow storage is synthesised.

Test Plan:
- Reset mid-PRESENT with snap_valid=1 → next cycle snap_valid=0, regAddr=0, busy=0, ch=0.
- Auto, NUM_CH=4, base_addr=2, dwell=0, READ_LAT=1, ready=1, regData=0x100+regAddr → snapshots (ch,data) = (0,0x102),(1,0x103),(2,0x104),(3,0x105),(0,0x102) with a 3-cycle period.
- Backpressure: ready=0 for 10 cycles in PRESENT → snap_valid, snap_ch and snap_data stable all 10 cycles, exactly one transfer when ready=1.
- Manual: mode=1, three step pulses (one issued while busy) → exactly two snapshots, ch 0 then 1. The step issued while busy produces nothing.
- Wrap/latency: ADDR_W=5, base_addr=30, READ_LAT=3, dwell=5 → regAddr 30,31,0,1. Data sampled 3 edges after each regAddr change. Period is 10 cycles.
- SM_SCAN_CHANGE_ONLY_EN: regData constant 0xDEAD for all channels → only the first four snapshots appear. Changing reg 3 to 0xBEEF → next snapshot is (ch 1, 0xBEEF) with base 2.

Source files
------------

// File: rtl/sm_reg_scanner.sv
// Register-watch sequencer: scans NUM_CH consecutive debug-port registers from base_addr and streams snapshots.
// Build option SM_SCAN_CHANGE_ONLY_EN: drop captures whose value matches the last one seen on that channel.
module sm_reg_scanner #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 4,
  parameter int DWELL_W  = 16,
  parameter int READ_LAT = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               step,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ADDR_W-1:0]  regAddr,
  input  logic [DATA_W-1:0]  regData,
  output logic               snap_valid,
  input  logic               snap_ready,
  output logic [CH_W-1:0]    snap_ch,
  output logic [DATA_W-1:0]  snap_data,
  output logic               busy
);

  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(READ_LAT);
  localparam logic [LAT_W-1:0]   LAT_ONE   = LAT_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]    CH_ONE    = CH_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT, DWELL} scanStateT;

  scanStateT          state, stateNext, postState;
  logic [CH_W-1:0]    ch, chNext, chInc;
  logic [ADDR_W-1:0]  addrNext, chAddr;
  logic [LAT_W-1:0]   latCnt, latCntNext;
  logic [DWELL_W-1:0] dwellCnt, dwellCntNext;
  logic               validNext;
  logic [CH_W-1:0]    snapChNext;
  logic [DATA_W-1:0]  snapDataNext;
  logic               capture;
  logic               suppress;

  assign busy    = (state != IDLE);
  assign capture = (state == WAIT) && (latCnt <= LAT_ONE);
  assign chInc   = (ch == CH_LAST) ? '0 : ch + CH_ONE;

  always_comb begin
    chAddr = '0;
    chAddr[CH_W-1:0] = ch;
  end

`ifdef SM_SCAN_CHANGE_ONLY_EN
  logic [NUM_CH-1:0] hit;

  // One shadow word per channel; a capture equal to the shadow is not presented.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gShadow
    logic [DATA_W-1:0] shadowVal;
    logic              seen;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadowVal <= '0;
        seen      <= 1'b0;
      end else if (capture && (ch == CH_W'(gi))) begin
        shadowVal <= regData;
        seen      <= 1'b1;
      end
    end

    assign hit[gi] = seen && (shadowVal == regData);
  end

  assign suppress = hit[ch];
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      regAddr    <= '0;
      latCnt     <= '0;
      dwellCnt   <= '0;
      snap_valid <= 1'b0;
      snap_ch    <= '0;
      snap_data  <= '0;
    end else begin
      state      <= stateNext;
      ch         <= chNext;
      regAddr    <= addrNext;
      latCnt     <= latCntNext;
      dwellCnt   <= dwellCntNext;
      snap_valid <= validNext;
      snap_ch    <= snapChNext;
      snap_data  <= snapDataNext;
    end
  end

  always_comb begin
    stateNext    = state;
    chNext       = ch;
    addrNext     = regAddr;
    latCntNext   = latCnt;
    dwellCntNext = dwellCnt;
    validNext    = snap_valid;
    snapChNext   = snap_ch;
    snapDataNext = snap_data;

    // Where a finished channel goes: dwell only while still running in auto mode.
    postState = (enable && !mode && (dwell != '0)) ? DWELL : IDLE;

    case (state)
      IDLE: begin
        if (enable && (!mode || step)) begin
          addrNext   = base_addr + chAddr;
          latCntNext = LAT_INIT;
          stateNext  = WAIT;
        end
      end

      WAIT: begin
        latCntNext = latCnt - LAT_ONE;
        if (capture) begin
          if (suppress) begin
            chNext    = chInc;
            stateNext = postState;
            if (postState == DWELL) dwellCntNext = dwell;
          end else begin
            snapDataNext = regData;
            snapChNext   = ch;
            validNext    = 1'b1;
            stateNext    = PRESENT;
          end
        end
      end

      PRESENT: begin
        if (snap_valid && snap_ready) begin
          validNext = 1'b0;
          chNext    = chInc;
          stateNext = postState;
          if (postState == DWELL) dwellCntNext = dwell;
        end
      end

      DWELL: begin
        if (!enable || mode) begin
          dwellCntNext = '0;
          stateNext    = IDLE;
        end else begin
          dwellCntNext = dwellCnt - DWELL_ONE;
          if (dwellCnt <= DWELL_ONE) stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule
